m_w_stage: RTL and testbench

- Memory-to-writeback pipeline register plus writeback-stage datapath.
- Sits directly downstream of the word-addressed data memory. Captures the raw 32-bit read word, the ALU result and the control fields at the M/W boundary.
- Performs byte/halfword load extraction and sign/zero extension in W, selects the register-file write data, and produces the forwarding source.
- Counts retired instructions.

---
 rtl/m_w_stage.sv | 133 +++++++++++++
 tb/tb_m_w_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/m_w_stage.sv
// Memory-to-writeback pipeline register with writeback-stage load extraction,
// register-file write select, alignment check and retired-instruction counter.
module m_w_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        M_valid,
    input  logic [31:0] M_pc,
    input  logic        M_reg_we,
    input  logic [4:0]  M_rd,
    input  logic        M_mem_to_reg,
    input  logic        M_link,
    input  logic [2:0]  M_load_type,
    input  logic [1:0]  M_addr_lo,
    input  logic [31:0] M_alu_res,
    input  logic [31:0] M_dm_rd,
    output logic        W_valid,
    output logic [31:0] W_pc,
    output logic        W_rf_we,
    output logic [4:0]  W_rf_addr,
    output logic [31:0] W_rf_wd,
    output logic        W_align_err,
    output logic [31:0] retire_cnt
);

    localparam logic [2:0] LdLw  = 3'd0;
    localparam logic [2:0] LdLb  = 3'd1;
    localparam logic [2:0] LdLbu = 3'd2;
    localparam logic [2:0] LdLh  = 3'd3;
    localparam logic [2:0] LdLhu = 3'd4;

    logic        valid_q;
    logic [31:0] pc_q;
    logic        reg_we_q;
    logic [4:0]  rd_q;
    logic        mem_to_reg_q;
    logic        link_q;
    logic [2:0]  load_type_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] alu_res_q;
    logic [31:0] dm_rd_q;
    logic [31:0] retire_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= RESET_PC;
            reg_we_q     <= 1'b0;
            rd_q         <= 5'd0;
            mem_to_reg_q <= 1'b0;
            link_q       <= 1'b0;
            load_type_q  <= 3'd0;
            addr_lo_q    <= 2'd0;
            alu_res_q    <= 32'd0;
            dm_rd_q      <= 32'd0;
            retire_q     <= 32'd0;
        end else if (flush) begin
            // Bubble keeps the PC for tracing; data fields are don't-care.
            valid_q      <= 1'b0;
            pc_q         <= M_pc;
            reg_we_q     <= 1'b0;
            rd_q         <= 5'd0;
            mem_to_reg_q <= 1'b0;
            link_q       <= 1'b0;
            load_type_q  <= M_load_type;
            addr_lo_q    <= M_addr_lo;
            alu_res_q    <= M_alu_res;
            dm_rd_q      <= M_dm_rd;
        end else if (!stall) begin
            valid_q      <= M_valid;
            pc_q         <= M_pc;
            reg_we_q     <= M_reg_we;
            rd_q         <= M_rd;
            mem_to_reg_q <= M_mem_to_reg;
            link_q       <= M_link;
            load_type_q  <= M_load_type;
            addr_lo_q    <= M_addr_lo;
            alu_res_q    <= M_alu_res;
            dm_rd_q      <= M_dm_rd;
            if (M_valid) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        is_half;
    logic        is_word;

    always_comb begin
        ld_byte = 8'd0;
        ld_half = addr_lo_q[1] ? dm_rd_q[31:16] : dm_rd_q[15:0];
        unique case (addr_lo_q)
            2'd0: ld_byte = dm_rd_q[7:0];
            2'd1: ld_byte = dm_rd_q[15:8];
            2'd2: ld_byte = dm_rd_q[23:16];
            2'd3: ld_byte = dm_rd_q[31:24];
            default: ld_byte = 8'd0;
        endcase
        is_half = (load_type_q == LdLh) || (load_type_q == LdLhu);
        is_word = !(is_half || (load_type_q == LdLb) || (load_type_q == LdLbu));
        case (load_type_q)
            LdLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LdLbu:   ld_data = {24'd0, ld_byte};
            LdLh:    ld_data = {{16{ld_half[15]}}, ld_half};
            LdLhu:   ld_data = {16'd0, ld_half};
            default: ld_data = dm_rd_q;
        endcase
    end

    always_comb begin
        W_valid     = valid_q;
        W_pc        = pc_q;
        W_rf_we     = valid_q & reg_we_q & (rd_q != 5'd0);
        W_rf_addr   = W_rf_we ? rd_q : 5'd0;
        W_align_err = valid_q & mem_to_reg_q &
                      ((is_half & addr_lo_q[0]) | (is_word & (addr_lo_q != 2'd0)));
        if (link_q) begin
            W_rf_wd = pc_q + 32'd8;
        end else if (mem_to_reg_q) begin
            W_rf_wd = ld_data;
        end else begin
            W_rf_wd = alu_res_q;
        end
        retire_cnt = retire_q;
    end

endmodule

// File: tb/tb_m_w_stage.sv
// Directed self-checking bench for m_w_stage: loads, link, $0, stall/flush,
// misalignment, reset priority and retire counter including wrap.
module tb_m_w_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        M_valid, M_reg_we, M_mem_to_reg, M_link;
    logic [31:0] M_pc, M_alu_res, M_dm_rd;
    logic [4:0]  M_rd;
    logic [2:0]  M_load_type;
    logic [1:0]  M_addr_lo;
    logic        W_valid, W_rf_we, W_align_err;
    logic [31:0] W_pc, W_rf_wd, retire_cnt;
    logic [4:0]  W_rf_addr;

    int checks = 0;
    int failures = 0;

    m_w_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .M_valid(M_valid), .M_pc(M_pc), .M_reg_we(M_reg_we), .M_rd(M_rd),
        .M_mem_to_reg(M_mem_to_reg), .M_link(M_link), .M_load_type(M_load_type),
        .M_addr_lo(M_addr_lo), .M_alu_res(M_alu_res), .M_dm_rd(M_dm_rd),
        .W_valid(W_valid), .W_pc(W_pc), .W_rf_we(W_rf_we), .W_rf_addr(W_rf_addr),
        .W_rf_wd(W_rf_wd), .W_align_err(W_align_err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic v, input logic [31:0] pc, input logic we,
                         input logic [4:0] rd, input logic m2r, input logic lnk,
                         input logic [2:0] lt, input logic [1:0] alo,
                         input logic [31:0] alu, input logic [31:0] dm);
        M_valid = v; M_pc = pc; M_reg_we = we; M_rd = rd; M_mem_to_reg = m2r;
        M_link = lnk; M_load_type = lt; M_addr_lo = alo; M_alu_res = alu; M_dm_rd = dm;
    endtask

    localparam logic [31:0] DM = 32'h80F1_7F82;

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_m(1, 32'h1234_5678, 1, 5'd7, 1, 1, 3'd1, 2'd3, 32'hCAFE_BABE, DM);
        tick(); tick();
        chk("rst_pc", W_pc, 32'h0000_3000);
        chk("rst_valid", {31'd0, W_valid}, 32'd0);
        chk("rst_we", {31'd0, W_rf_we}, 32'd0);
        chk("rst_addr", {27'd0, W_rf_addr}, 32'd0);
        chk("rst_wd", W_rf_wd, 32'd0);
        chk("rst_align", {31'd0, W_align_err}, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        reset = 1'b0;

        set_m(1, 32'h3004, 1, 5'd8, 1, 0, 3'd1, 2'd0, 32'hDEAD_0000, DM);
        tick();
        chk("lb_wd", W_rf_wd, 32'hFFFF_FF82);
        chk("lb_we", {31'd0, W_rf_we}, 32'd1);
        chk("lb_addr", {27'd0, W_rf_addr}, 32'd8);
        chk("lb_pc", W_pc, 32'h3004);
        chk("lb_cnt", retire_cnt, 32'd1);
        set_m(1, 32'h3008, 1, 5'd8, 1, 0, 3'd2, 2'd3, 32'hDEAD_0003, DM);
        tick();
        chk("lbu_wd", W_rf_wd, 32'h0000_0080);
        set_m(1, 32'h300C, 1, 5'd8, 1, 0, 3'd3, 2'd2, 32'hDEAD_0002, DM);
        tick();
        chk("lh_wd", W_rf_wd, 32'hFFFF_80F1);
        chk("lh_align", {31'd0, W_align_err}, 32'd0);
        set_m(1, 32'h3010, 1, 5'd8, 1, 0, 3'd4, 2'd0, 32'hDEAD_0000, DM);
        tick();
        chk("lhu_wd", W_rf_wd, 32'h0000_7F82);
        set_m(1, 32'h3014, 1, 5'd8, 1, 0, 3'd0, 2'd0, 32'hDEAD_0000, DM);
        tick();
        chk("lw_wd", W_rf_wd, 32'h80F1_7F82);
        chk("lw_align", {31'd0, W_align_err}, 32'd0);
        chk("lw_cnt", retire_cnt, 32'd5);

        set_m(1, 32'h0000_3010, 1, 5'd31, 0, 1, 3'd0, 2'd0, 32'h5555_5555, 32'd0);
        tick();
        chk("link_wd", W_rf_wd, 32'h0000_3018);
        chk("link_we", {31'd0, W_rf_we}, 32'd1);
        chk("link_addr", {27'd0, W_rf_addr}, 32'd31);
        set_m(1, 32'h0000_3010, 1, 5'd0, 0, 1, 3'd0, 2'd0, 32'h5555_5555, 32'd0);
        tick();
        chk("r0_we", {31'd0, W_rf_we}, 32'd0);
        chk("r0_addr", {27'd0, W_rf_addr}, 32'd0);
        chk("r0_wd", W_rf_wd, 32'h0000_3018);

        set_m(1, 32'h3020, 1, 5'd9, 1, 0, 3'd3, 2'd1, 32'h1, DM);
        tick();
        chk("mis_lh_err", {31'd0, W_align_err}, 32'd1);
        chk("mis_lh_wd", W_rf_wd, 32'h0000_7F82);
        set_m(1, 32'h3024, 1, 5'd9, 1, 0, 3'd0, 2'd2, 32'h2, DM);
        tick();
        chk("mis_lw_err", {31'd0, W_align_err}, 32'd1);
        chk("mis_lw_wd", W_rf_wd, DM);
        chk("mis_cnt", retire_cnt, 32'd9);

        set_m(1, 32'h3040, 1, 5'd5, 0, 0, 3'd0, 2'd0, 32'h1234_5678, 32'd0);
        tick();
        chk("a_wd", W_rf_wd, 32'h1234_5678);
        chk("a_cnt", retire_cnt, 32'd10);
        stall = 1'b1;
        set_m(1, 32'h3044, 1, 5'd6, 0, 0, 3'd0, 2'd0, 32'h0000_AAAA, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_wd", W_rf_wd, 32'h1234_5678);
            chk("stall_addr", {27'd0, W_rf_addr}, 32'd5);
            chk("stall_pc", W_pc, 32'h3040);
            chk("stall_cnt", retire_cnt, 32'd10);
        end
        flush = 1'b1;
        tick();
        chk("sf_valid", {31'd0, W_valid}, 32'd0);
        chk("sf_we", {31'd0, W_rf_we}, 32'd0);
        chk("sf_addr", {27'd0, W_rf_addr}, 32'd0);
        chk("sf_pc", W_pc, 32'h3044);
        chk("sf_cnt", retire_cnt, 32'd10);
        flush = 1'b0;

        reset = 1'b1;
        tick();
        chk("rst_stall_pc", W_pc, 32'h0000_3000);
        chk("rst_stall_cnt", retire_cnt, 32'd0);
        chk("rst_stall_valid", {31'd0, W_valid}, 32'd0);
        reset = 1'b0; stall = 1'b0;

        // 5 valid captures, 2 bubbles and 1 flush (with M_valid=1, not counted)
        set_m(1, 32'h3100, 1, 5'd1, 0, 0, 3'd0, 2'd0, 32'h11, 32'd0);
        tick(); tick();
        M_valid = 1'b0;
        tick();
        chk("bub_we", {31'd0, W_rf_we}, 32'd0);
        M_valid = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        chk("cf_valid", {31'd0, W_valid}, 32'd0);
        chk("cf_cnt", retire_cnt, 32'd3);
        flush = 1'b0;
        tick();
        M_valid = 1'b0;
        tick();
        M_valid = 1'b1;
        tick();
        chk("cnt5", retire_cnt, 32'd5);

        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        tick();
        chk("cnt_wrap", retire_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
